scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_next_ch.sv | 29 ++
 rtl/scan_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the scan sequencer
package scan_pkg;

    localparam int NUM_CH           = 8;
    localparam int SEL_W            = 3;
    localparam int BLANK_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// rtl/scan_next_ch.sv - next enabled channel strictly above cur, wrapping; wrap flags frame end
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Offset NUM_CH folds back onto cur itself, which covers the single-bit mask.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - channel scan sequencer with per-step dwell and frame pulse
// Optional inter-step blanking gap: define SCAN_BLANK_EN.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               oneshot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  ch_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_vld,
    output logic               frame_done,
    output logic               busy
);

`ifdef SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif
    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [3:0]         bcnt;
    logic [SEL_W-1:0]   pend;

    logic [SEL_W-1:0]   search_cur;
    logic [SEL_W-1:0]   step_nxt;
    logic               step_wrap;
    logic [SEL_W-1:0]   start_sel;
    logic [NUM_CH-1:0]  above;
    logic               peek_wrap;
    logic               mask_any;
    logic [DWELL_W-1:0] load;
    logic               last_one;
    logic               start_fd;

    // From IDLE, searching above the top channel yields the lowest set bit.
    assign search_cur = (state == IDLE) ? SEL_W'(NUM_CH - 1) : sel;

    scan_next_ch u_next (
        .cur  (search_cur),
        .mask (ch_mask),
        .nxt  (step_nxt),
        .wrap (step_wrap)
    );

    assign start_sel = (state == BLANK) ? pend : step_nxt;
    assign mask_any  = |ch_mask;
    assign load      = (dwell == '0) ? '0 : dwell - 1'b1;
    assign last_one  = (dwell <= DWELL_W'(1));

    // A one-cycle step must raise frame_done on entry, so look ahead at its wrap.
    assign above     = ch_mask >> start_sel;
    assign peek_wrap = (above[NUM_CH-1:1] == '0);
    assign start_fd  = last_one && peek_wrap && mask_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            sel_vld    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            bcnt       <= '0;
            pend       <= '0;
        end else if (!en) begin
            state      <= IDLE;
            sel_vld    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mask_any) begin
                        state      <= DWELL;
                        sel        <= start_sel;
                        sel_vld    <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= load;
                        frame_done <= start_fd;
                    end else begin
                        sel_vld    <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end
                end
                DWELL: begin
                    if (cnt != '0) begin
                        cnt        <= cnt - 1'b1;
                        frame_done <= (cnt == DWELL_W'(1)) && step_wrap && mask_any;
                    end else if (!mask_any || (step_wrap && oneshot)) begin
                        state      <= IDLE;
                        sel_vld    <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end else if (BLANK_ON) begin
                        state      <= BLANK;
                        bcnt       <= BLANK_LOAD;
                        pend       <= step_nxt;
                        sel_vld    <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        sel        <= start_sel;
                        cnt        <= load;
                        frame_done <= start_fd;
                    end
                end
                BLANK: begin
                    if (bcnt != '0) begin
                        bcnt <= bcnt - 1'b1;
                    end else if (!mask_any) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= DWELL;
                        sel        <= start_sel;
                        sel_vld    <= 1'b1;
                        cnt        <= load;
                        frame_done <= start_fd;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sel_vld    <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
